demux_rr_scheduler: RTL
=======================

// Module: demux_rr_scheduler
// PURPOSE
//   Round-robin scheduler that shares a 1-bit serial input stream among four lane consumers.
//   Drives the select of an internal 1-to-4 demux and grants each ready lane a burst of beats before rotating.
//   Sits between a single serial producer (valid/ready) and four lane sinks; replaces a free-running select.
// PARAMETERS
//   LANES   4   number of output lanes; fixed at 4 in this revision
//   SEL_W   2   select width, clog2(LANES)
//   BURST   4   maximum beats granted per lane before rotating; legal range 1..15
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      reset: synchronous, active-low
//   en          in   1      scheduler enable; 0 forces IDLE and zeroes outputs
//   in_valid    in   1      producer has a beat on in_data
//   in_data     in   1      serial data bit
//   in_ready    out  1      beat accepted this cycle when in_valid && in_ready
//   lane_ready  in   4      per-lane sink can accept a beat
//   s           out  2      current lane select (registered)
//   y           out  4      demuxed data, one-hot lane position, registered
//   y_valid     out  4      one-hot strobe qualifying y
//   busy        out  1      1 while in ARB or XFER
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE, ptr=3, beat_cnt=0, s=0, y=0, y_valid=0, in_ready=0, busy=0.
//   FSM states: IDLE, ARB, XFER.
//   - IDLE: in_ready=0. If en=1 -> ARB on the next edge.
//   - ARB (1 cycle min): search lanes ptr+1, ptr+2, ... mod 4; the first lane with lane_ready=1 is granted.
//     s<=grant, beat_cnt<=0, ->XFER. If no lane is ready, stay in ARB; in_ready=0.
//   - XFER: in_ready = lane_ready[s] (combinational). Accept = in_valid && in_ready.
//     On accept: beat_cnt++. If beat_cnt==BURST-1: ptr<=s, ->ARB.
//     If lane_ready[s]=0: burst truncated, ptr<=s, ->ARB on the next edge. No beat is accepted that cycle.
//     If in_valid=0: the grant is held, with no timeout.
//   Datapath latency is 1 cycle. The cycle after an accept, y is all zero except y[s]=in_data, and y_valid is one-hot at s.
//     In every other cycle, y=0 and y_valid=0.
//   en=0 in any state: in_ready=0 immediately (combinational gate). The next edge gives IDLE, y=0, y_valid=0.
//     A beat that is in flight at that edge is dropped. ptr is kept.
//   Reset mid-burst: all state returns to reset values. Any partial burst is discarded without error.
//   Simultaneous events: a final-beat accept together with lane_ready dropping counts as a normal burst end.
//   en=0 has priority over every other event.
//   Wrap-around: ptr 3 -> next search starts at lane 0. beat_cnt is 4 bits and never exceeds BURST-1.
//   A single ready lane is re-granted after each burst, with 1 ARB bubble cycle between bursts.
// CONFIGURATION
//   Macro DEMUX_SCHED_STATS_EN:
//   - Defined: adds output lane_cnt [31:0], four 8-bit saturating beat counters, lane k at bits [8k+7:8k].
//     Each counter increments on an accept to lane k. Reset clears them to 0. en=0 holds their values. Counters stick at 255.
//   - Undefined: no lane_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//   Package demux_sched_pkg holds:
//   - LANES and SEL_W localparams.
//   - typedef enum logic [1:0] {IDLE, ARB, XFER} sched_state_t.
//   - function next_rr(ptr, ready), which returns the grant lane and a found flag.
//   Sub-module demux_1to4_reg: registered 1-to-4 demux (en, i, s -> y, y_valid), reset to 0.
//   The scheduler instantiates it with en = accept.
// TESTING
//   1 Reset, en=1, all lane_ready=1, in_valid=1, data 1010 1100 ...
//     -> lanes granted 0,1,2,3,0 with 4 beats each. y_valid one-hot follows 1 cycle after accept. 1 ARB bubble between bursts.
//   2 Only lane_ready=4'b0100 -> s=2 for every burst, and in_ready is 0 during each ARB cycle.
//   3 lane 1 drops lane_ready after 2 beats -> in_ready=0 that cycle. The next grant is lane 2, and y_valid shows 2 pulses on lane 1.
//   4 lane_ready=0 for 10 cycles -> FSM stays in ARB, busy=1, in_ready=0, y_valid=0.
//     Then lane 3 rises -> s=3 one cycle later.
//   5 en=0 mid-burst at beat 2 -> in_ready=0 the same cycle, IDLE and y=0 next cycle.
//     After en=1, the search resumes at lane ptr+1 and the beat count restarts.
//   6 rst_n=0 during XFER -> all outputs 0 next edge, and the first grant after release is lane 0.
//     With DEMUX_SCHED_STATS_EN: 300 beats on lane 0 -> lane_cnt[7:0]=255.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types, sizes and the round-robin search helper for demux_rr_scheduler.
package demux_sched_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned STAT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] lane;
  } rr_grant_t;

  // First ready lane after ptr, wrapping; ptr itself is checked last.
  function automatic rr_grant_t next_rr(input logic [SEL_W-1:0] ptr,
                                        input logic [LANES-1:0] ready);
    rr_grant_t        g;
    logic [SEL_W-1:0] idx;
    g = '0;
    for (int unsigned k = 1; k <= LANES; k++) begin
      idx = ptr + SEL_W'(k);
      if (!g.found && ready[idx]) begin
        g.found = 1'b1;
        g.lane  = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demux: steers one data bit to the selected lane with a one-hot strobe.
module demux_1to4_reg
  import demux_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             i_i,
  input  logic [SEL_W-1:0] s_i,
  output logic [LANES-1:0] y_o,
  output logic [LANES-1:0] y_valid_o
);

  // One-cycle pulse on the selected lane; all lanes quiet otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_o       <= '0;
      y_valid_o <= '0;
    end else if (en_i) begin
      y_o       <= LANES'(i_i) << s_i;
      y_valid_o <= LANES'(1) << s_i;
    end else begin
      y_o       <= '0;
      y_valid_o <= '0;
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler sharing one serial valid/ready stream among four lanes.
// Optional per-lane saturating beat counters on lane_cnt when DEMUX_SCHED_STATS_EN is defined.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  input  logic [LANES-1:0] lane_ready,
  output logic [SEL_W-1:0] s,
  output logic [LANES-1:0] y,
  output logic [LANES-1:0] y_valid,
  output logic             busy
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [LANES*STAT_W-1:0] lane_cnt
`endif
);

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             busy_q;
  logic             accept;
  rr_grant_t        grant;

  // State and scheduling registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= SEL_W'(LANES - 1);
      s_q        <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s_q        <= s_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // Next-state: enable gate, round-robin grant, burst counting and truncation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    s_d        = s_q;
    beat_cnt_d = beat_cnt_q;
    grant      = next_rr(ptr_q, lane_ready);
    if (!en) begin
      state_d    = IDLE;
      s_d        = '0;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARB;
        ARB: begin
          if (grant.found) begin
            s_d        = grant.lane;
            beat_cnt_d = '0;
            state_d    = XFER;
          end
        end
        XFER: begin
          if (!lane_ready[s_q]) begin
            ptr_d   = s_q;
            state_d = ARB;
          end else if (accept) begin
            if (beat_cnt_q == CNT_W'(BURST - 1)) begin
              ptr_d      = s_q;
              beat_cnt_d = '0;
              state_d    = ARB;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: ready follows the granted lane only while transferring and enabled.
  always_comb begin
    in_ready = 1'b0;
    if (en && (state_q == XFER)) begin
      in_ready = lane_ready[s_q];
    end
    accept = in_valid && in_ready;
  end

  assign s    = s_q;
  assign busy = busy_q;

  demux_1to4_reg u_demux (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (accept),
    .i_i       (in_data),
    .s_i       (s_q),
    .y_o       (y),
    .y_valid_o (y_valid)
  );

`ifdef DEMUX_SCHED_STATS_EN
  logic [LANES-1:0][STAT_W-1:0] lane_cnt_q;

  // Per-lane accepted-beat counters that stick at full scale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (accept && (s_q == SEL_W'(k)) && (lane_cnt_q[k] != {STAT_W{1'b1}})) begin
          lane_cnt_q[k] <= lane_cnt_q[k] + STAT_W'(1);
        end
      end
    end
  end

  assign lane_cnt = lane_cnt_q;
`endif

endmodule
